bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the three seven-segment digit decoders in the lab top level.
- Converts a WIDTH-bit unsigned value into DIGITS packed BCD nibbles.
- Each nibble drives one decoder's 4-bit BIN input.
- Start/busy/done handshake lets a counter or switch-sampling stage request conversions.

Parameters:
WIDTH, 8, bit width of unsigned binary input; 10^DIGITS must exceed 2^WIDTH-1
DIGITS, 3, number of BCD output nibbles

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
START  input  1  conversion request, sampled on CLK rising edge
BIN_IN  input  WIDTH  unsigned value, captured only when START is accepted
BUSY  output  1  high while a conversion is in progress
DONE  output  1  one-cycle pulse when BCD holds a new result
BCD  output  4*DIGITS  packed result; nibble [3:0] = ones, [7:4] = tens, [11:8] = hundreds

Behaviour:
- Reset:
  - RST high asynchronously forces state IDLE, BCD=0, BUSY=0, DONE=0, and clears internal shift/count registers.
  - Reset asserted mid-conversion aborts it; no DONE follows.
- States: IDLE, CONV.
- IDLE:
  - START=1 at an edge captures BIN_IN into the shift register, clears the BCD scratch register, loads bit counter = WIDTH, and moves to CONV.
  - BUSY=1 from that edge.
- CONV, each edge:
  - Every scratch nibble >= 5 gets +3, nibble-local, 4-bit.
  - Then {scratch, shift} shifts left by one; counter decrements.
  - On the edge where counter reaches 0: BCD <= final scratch value, DONE=1 for exactly one cycle, BUSY=0, state returns to IDLE.
- Latency: DONE is high in the cycle starting WIDTH edges after the START-accept edge (8 for the default).
- BCD is registered and holds its last result until the next DONE. It never shows intermediate values.
- START is ignored while BUSY=1; no queueing.
- START high in the cycle where DONE=1 is accepted, since the FSM is in IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- Holding START high continuously yields repeated conversions, each sampling BIN_IN at its accept edge.
- BIN_IN changes after capture do not affect the running conversion.
- Unused high digits (value below 10^(DIGITS-1)) output 0, not blank.

Optional Feature:
Macro BIN2BCD_HEXMODE_EN.
- Defined: adds input port HEX (1 bit), sampled with START.
  - HEX=1 at accept: BCD <= BIN_IN zero-extended/truncated to 4*DIGITS bits, as raw hex nibbles.
  - DONE is pulsed on the next edge (latency 1); BUSY is high for that one cycle.
  - HEX=0 at accept: normal decimal conversion.
- Undefined: HEX port absent; always decimal; behaviour exactly as above.

Test Plan:
- Reset, then START with BIN_IN=255 -> BUSY high 8 cycles; DONE one cycle at edge 8; BCD=12'h255.
- BIN_IN=0 and BIN_IN=199 conversions -> BCD=12'h000 then 12'h199. BCD unchanged between DONE pulses.
- START with BIN_IN=100, change BIN_IN to 37 and pulse START at cycle 3 -> second START ignored; BCD=12'h100; only one DONE.
- START with BIN_IN=42, START again in the DONE cycle with BIN_IN=7 -> BCD=12'h042, then 12'h007 nine cycles after the first DONE.
- START with BIN_IN=250, assert RST at cycle 4 -> BCD=0, BUSY=0, no DONE; a new START with 9 after release -> BCD=12'h009.
- (BIN2BCD_HEXMODE_EN) HEX=1, BIN_IN=8'hAB -> DONE one edge later, BCD=12'h0AB; HEX=0, same value -> BCD=12'h171 after 8 cycles.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. Feeds packed BCD nibbles to seven-segment
// digit decoders.
//
// Ports:
//   CLK     rising-edge clock
//   RST     asynchronous active-high reset
//   START   conversion request, sampled on CLK rising edge while idle
//   BIN_IN  WIDTH-bit unsigned value, captured when START is accepted
//   HEX     (only with BIN2BCD_HEXMODE_EN) 1 = pass BIN_IN through as raw
//           hex nibbles with a one-cycle latency instead of converting
//   BUSY    high while a conversion is in progress
//   DONE    one-cycle pulse when BCD holds a new result
//   BCD     packed result, nibble [3:0] = ones, [7:4] = tens, ...
//
// Optional feature macro: BIN2BCD_HEXMODE_EN (adds the HEX input).
//
// Timing: START accepted at edge 0, DONE high in the cycle after edge
// WIDTH. BCD only updates together with DONE, so intermediate scratch
// values are never visible.

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN_IN,
`ifdef BIN2BCD_HEXMODE_EN
  input  logic                  HEX,
`endif
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;

  // One shift-and-add-3 step: nibble-local correction, then shift left.
  logic [BW-1:0]         adj;
  logic [BW+WIDTH-1:0]   step_cat;
  logic [BW-1:0]         scratch_step;
  logic [WIDTH-1:0]      shift_step;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                              (scratch_q[gi*4 +: 4] + 4'd3) :
                              scratch_q[gi*4 +: 4];
    end
  endgenerate

  assign step_cat     = {adj, shift_q} << 1;
  assign scratch_step = step_cat[BW+WIDTH-1:WIDTH];
  assign shift_step   = step_cat[WIDTH-1:0];

`ifdef BIN2BCD_HEXMODE_EN
  localparam int HW = (WIDTH < BW) ? WIDTH : BW;

  logic          hex_q, hex_d;
  logic [BW-1:0] hex_val;

  // Raw pass-through, zero-extended or truncated to the BCD width. The
  // shift register still holds the captured value on the single CONV edge.
  always_comb begin
    hex_val         = '0;
    hex_val[HW-1:0] = shift_q[HW-1:0];
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
`ifdef BIN2BCD_HEXMODE_EN
      hex_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
`ifdef BIN2BCD_HEXMODE_EN
      hex_q     <= hex_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef BIN2BCD_HEXMODE_EN
    hex_d     = hex_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          shift_d   = BIN_IN;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = CONV;
`ifdef BIN2BCD_HEXMODE_EN
          hex_d     = HEX;
          // Hex pass-through finishes on the very next edge.
          if (HEX) begin
            cnt_d = CW'(1);
          end
`endif
        end
      end

      CONV: begin
        scratch_d = scratch_step;
        shift_d   = shift_step;
        cnt_d     = cnt_q - CW'(1);
        // Last bit consumed on this edge: publish the result.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = scratch_step;
`ifdef BIN2BCD_HEXMODE_EN
          if (hex_q) begin
            bcd_d = hex_val;
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY = (state_q == CONV);
  assign DONE = done_q;
  assign BCD  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. The reference model computes the
// expected BCD with plain decimal arithmetic (repeated /10 and %10).

module tb_bin2bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic [W-1:0]   BIN_IN;
  logic           BUSY;
  logic           DONE;
  logic [4*D-1:0] BCD;
`ifdef BIN2BCD_HEXMODE_EN
  logic           HEX;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected content of BCD as seen from outside (last published result).
  logic [4*D-1:0] model_bcd;

  always #5 CLK = ~CLK;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .BIN_IN (BIN_IN),
`ifdef BIN2BCD_HEXMODE_EN
    .HEX    (HEX),
`endif
    .BUSY   (BUSY),
    .DONE   (DONE),
    .BCD    (BCD)
  );

  function automatic logic [4*D-1:0] ref_bcd(input int v);
    int d;
    logic [4*D-1:0] r;
    d = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  // Advance one clock; outputs are sampled and inputs changed 1ns after.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST    = 1'b1;
    START  = 1'b0;
    BIN_IN = '0;
    repeat (3) step();
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || BCD !== '0) begin
      n_err++;
      $display("FAIL reset_state busy=%b done=%b bcd=%h required 0/0/000", BUSY, DONE, BCD);
    end
    RST = 1'b0;
    step();
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || BCD !== '0) begin
      n_err++;
      $display("FAIL reset_release busy=%b done=%b bcd=%h required 0/0/000", BUSY, DONE, BCD);
    end
    model_bcd = '0;
    $display("reset: checked idle state");
  endtask

  task automatic test_basic();
    int vals[3] = '{255, 0, 199};
    logic [4*D-1:0] exp;
    foreach (vals[i]) begin
      exp    = ref_bcd(vals[i]);
      START  = 1'b1;
      BIN_IN = W'(vals[i]);
      step();
      START  = 1'b0;
      BIN_IN = W'($urandom_range(255, 0));
      n_cmp++;
      if (BUSY !== 1'b1) begin
        n_err++;
        $display("FAIL basic_busy_start v=%0d busy=%b required 1", vals[i], BUSY);
      end
      for (int k = 1; k <= W; k++) begin
        step();
        n_cmp++;
        if (k < W) begin
          if (BUSY !== 1'b1 || DONE !== 1'b0 || BCD !== model_bcd) begin
            n_err++;
            $display("FAIL basic_conv v=%0d k=%0d busy=%b done=%b bcd=%h required 1/0/%h",
                     vals[i], k, BUSY, DONE, BCD, model_bcd);
          end
        end else begin
          if (BUSY !== 1'b0 || DONE !== 1'b1 || BCD !== exp) begin
            n_err++;
            $display("FAIL basic_done v=%0d busy=%b done=%b bcd=%h required 0/1/%h",
                     vals[i], BUSY, DONE, BCD, exp);
          end
        end
      end
      model_bcd = exp;
      step();
      n_cmp++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || BCD !== model_bcd) begin
        n_err++;
        $display("FAIL basic_hold v=%0d busy=%b done=%b bcd=%h required 0/0/%h",
                 vals[i], BUSY, DONE, BCD, model_bcd);
      end
      $display("basic: BIN_IN=%0d -> BCD=%h expected %h", vals[i], BCD, exp);
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int done_k;
    ndone  = 0;
    done_k = -1;
    START  = 1'b1;
    BIN_IN = W'(100);
    step();
    START  = 1'b0;
    for (int k = 1; k <= W + 8; k++) begin
      step();
      if (k == 3) begin
        START  = 1'b1;
        BIN_IN = W'(37);
      end
      if (k == 4) begin
        START = 1'b0;
      end
      if (DONE === 1'b1) begin
        ndone++;
        done_k = k;
      end
    end
    model_bcd = ref_bcd(100);
    n_cmp++;
    if (ndone != 1 || done_k != W) begin
      n_err++;
      $display("FAIL ignore_done_count dones=%0d at_edge=%0d required 1 at %0d", ndone, done_k, W);
    end
    n_cmp++;
    if (BCD !== model_bcd) begin
      n_err++;
      $display("FAIL ignore_value bcd=%h required %h", BCD, model_bcd);
    end
    $display("start_ignored: BCD=%h dones=%0d", BCD, ndone);
  endtask

  task automatic test_back_to_back();
    START  = 1'b1;
    BIN_IN = W'(42);
    step();
    START  = 1'b0;
    repeat (W) step();
    n_cmp++;
    if (DONE !== 1'b1 || BCD !== ref_bcd(42)) begin
      n_err++;
      $display("FAIL b2b_first done=%b bcd=%h required 1/%h", DONE, BCD, ref_bcd(42));
    end
    model_bcd = ref_bcd(42);
    START  = 1'b1;
    BIN_IN = W'(7);
    step();
    START  = 1'b0;
    BIN_IN = W'(200);
    n_cmp++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || BCD !== model_bcd) begin
      n_err++;
      $display("FAIL b2b_accept busy=%b done=%b bcd=%h required 1/0/%h", BUSY, DONE, BCD, model_bcd);
    end
    repeat (W - 1) step();
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_early done=%b required 0", DONE);
    end
    step();
    n_cmp++;
    if (DONE !== 1'b1 || BCD !== ref_bcd(7)) begin
      n_err++;
      $display("FAIL b2b_second done=%b bcd=%h required 1/%h", DONE, BCD, ref_bcd(7));
    end
    model_bcd = ref_bcd(7);
    step();
    $display("back_to_back: 42 then 7, BCD=%h", BCD);
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone  = 0;
    START  = 1'b1;
    BIN_IN = W'(250);
    step();
    START  = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    #1;
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || BCD !== '0) begin
      n_err++;
      $display("FAIL abort_async busy=%b done=%b bcd=%h required 0/0/000", BUSY, DONE, BCD);
    end
    step();
    RST = 1'b0;
    model_bcd = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (DONE === 1'b1 || BUSY === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0 || BCD !== '0) begin
      n_err++;
      $display("FAIL abort_quiet activity=%0d bcd=%h required 0/000", ndone, BCD);
    end
    START  = 1'b1;
    BIN_IN = W'(9);
    step();
    START  = 1'b0;
    repeat (W) step();
    n_cmp++;
    if (DONE !== 1'b1 || BCD !== ref_bcd(9)) begin
      n_err++;
      $display("FAIL abort_restart done=%b bcd=%h required 1/%h", DONE, BCD, ref_bcd(9));
    end
    model_bcd = ref_bcd(9);
    step();
    $display("reset_abort: restart BCD=%h", BCD);
  endtask

  task automatic test_hold_start();
    int cur;
    cur    = int'($urandom_range(255, 0));
    START  = 1'b1;
    BIN_IN = W'(cur);
    step();
    for (int n = 0; n < 3; n++) begin
      for (int k = 1; k <= W; k++) begin
        BIN_IN = W'($urandom_range(255, 0));
        step();
      end
      n_cmp++;
      if (DONE !== 1'b1 || BCD !== ref_bcd(cur)) begin
        n_err++;
        $display("FAIL hold_result n=%0d v=%0d done=%b bcd=%h required 1/%h",
                 n, cur, DONE, BCD, ref_bcd(cur));
      end
      $display("hold_start: n=%0d v=%0d BCD=%h expected %h", n, cur, BCD, ref_bcd(cur));
      model_bcd = ref_bcd(cur);
      cur    = int'($urandom_range(255, 0));
      BIN_IN = W'(cur);
      if (n == 2) START = 1'b0;
      step();
      n_cmp++;
      if (DONE !== 1'b0 || BUSY !== (n != 2)) begin
        n_err++;
        $display("FAIL hold_accept n=%0d busy=%b done=%b required %b/0", n, BUSY, DONE, n != 2);
      end
    end
  endtask

  task automatic test_random();
    int v;
    int kp;
    logic [4*D-1:0] exp;
    for (int it = 0; it < 20; it++) begin
      v      = int'($urandom_range(255, 0));
      kp     = int'($urandom_range(W - 2, 1));
      exp    = ref_bcd(v);
      START  = 1'b1;
      BIN_IN = W'(v);
      step();
      START  = 1'b0;
      for (int k = 1; k <= W; k++) begin
        step();
        START = (k == kp);
        if (k == kp) BIN_IN = W'($urandom_range(255, 0));
        if (k < W) begin
          n_cmp++;
          if (DONE !== 1'b0 || BCD !== model_bcd) begin
            n_err++;
            $display("FAIL rand_conv it=%0d k=%0d done=%b bcd=%h required 0/%h",
                     it, k, DONE, BCD, model_bcd);
          end
        end
      end
      START = 1'b0;
      n_cmp++;
      if (DONE !== 1'b1 || BCD !== exp) begin
        n_err++;
        $display("FAIL rand_done it=%0d v=%0d done=%b bcd=%h required 1/%h", it, v, DONE, BCD, exp);
      end
      $display("random: it=%0d v=%0d BCD=%h expected %h", it, v, BCD, exp);
      model_bcd = exp;
      repeat ($urandom_range(2, 1)) step();
    end
  endtask

`ifdef BIN2BCD_HEXMODE_EN
  task automatic test_hex();
    HEX    = 1'b1;
    START  = 1'b1;
    BIN_IN = 8'hAB;
    step();
    START  = 1'b0;
    HEX    = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      n_err++;
      $display("FAIL hex_busy busy=%b done=%b required 1/0", BUSY, DONE);
    end
    step();
    n_cmp++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || BCD !== 12'h0AB) begin
      n_err++;
      $display("FAIL hex_done busy=%b done=%b bcd=%h required 0/1/0ab", BUSY, DONE, BCD);
    end
    $display("hex: BIN_IN=ab HEX=1 -> BCD=%h", BCD);
    step();
    START  = 1'b1;
    BIN_IN = 8'hAB;
    step();
    START  = 1'b0;
    repeat (W) step();
    n_cmp++;
    if (DONE !== 1'b1 || BCD !== ref_bcd(171)) begin
      n_err++;
      $display("FAIL hex_decimal done=%b bcd=%h required 1/%h", DONE, BCD, ref_bcd(171));
    end
    $display("hex: BIN_IN=ab HEX=0 -> BCD=%h", BCD);
    model_bcd = ref_bcd(171);
    step();
  endtask
`endif

  initial begin
`ifdef BIN2BCD_HEXMODE_EN
    HEX = 1'b0;
`endif
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_hold_start();
    test_random();
`ifdef BIN2BCD_HEXMODE_EN
    test_hex();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
